// File: rtl/dac_audio_mixer_if.sv
// dac_audio_mixer_if -- audio-side bus of the DAC mixer.
//
// Carries the three signed channel samples with their gains and mask, the
// audio enable, and the offset-binary DAC sample with its strobe and clip
// flag. MSBI and IW must match the parameters of the attached mixer.
//
// Handshake: SAMPLE_STB is a valid-only strobe with no ready. DAC_OUT is
// valid, and CLIP is meaningful, in the single cycle SAMPLE_STB is high. The
// DAC cannot push back. The channel inputs are sampled only at the mixer's
// snapshot instant and need no qualifier.
//
// Modports:
//   master - source side (drives channels/EN, receives DAC sample)
//   slave  - mixer side
interface dac_audio_mixer_if #(
  parameter int MSBI = 13,
  parameter int IW   = 12
);
  logic                 EN;
  logic signed [IW-1:0] CH0_IN;
  logic signed [IW-1:0] CH1_IN;
  logic signed [IW-1:0] CH2_IN;
  logic [3:0]           CH0_VOL;
  logic [3:0]           CH1_VOL;
  logic [3:0]           CH2_VOL;
  logic [2:0]           CH_MASK;
  logic [MSBI:0]        DAC_OUT;
  logic                 SAMPLE_STB;
  logic                 CLIP;

  modport master (
    output EN, CH0_IN, CH1_IN, CH2_IN, CH0_VOL, CH1_VOL, CH2_VOL, CH_MASK,
    input  DAC_OUT, SAMPLE_STB, CLIP
  );

  modport slave (
    input  EN, CH0_IN, CH1_IN, CH2_IN, CH0_VOL, CH1_VOL, CH2_VOL, CH_MASK,
    output DAC_OUT, SAMPLE_STB, CLIP
  );
endinterface

// File: rtl/dac_audio_mixer.sv
// dac_audio_mixer -- sample-rate sequencer and mixer feeding the sigma-delta
// DAC input.
//
// Every CLK_DIV clocks the three channels are snapshotted. They are then
// multiply-accumulated through one shared multiplier (one channel per
// cycle), scaled and saturated. The result is slew-limited and presented as
// an offset-binary (excess 2**MSBI) DAC sample.
//
// Ports:
//   CLK       - system clock
//   RESET     - synchronous, active-high reset
//   bus       - dac_audio_mixer_if.slave (channels, gains, mask, EN, DAC
//               sample, SAMPLE_STB, CLIP)
//   dbg_state - current sequencer state (state_t encoding)
module dac_audio_mixer #(
  parameter int MSBI      = 13,
  parameter int IW        = 12,
  parameter int CLK_DIV   = 256,
  parameter int RAMP_STEP = 1024
) (
  input  logic              CLK,
  input  logic              RESET,
  dac_audio_mixer_if.slave  bus,
  output logic [2:0]        dbg_state
);

  localparam int DW = (CLK_DIV <= 2) ? 1 : $clog2(CLK_DIV);
  localparam int AW = IW + 6;          // accumulator: 3 x (IW+5) products
  localparam int PW = IW + 5;          // product: signed IW x unsigned 4
  localparam int SH = MSBI + 1 - IW;   // left alignment of acc into DAC range
  localparam int MW = AW + SH;         // full width of the scaled mix

  localparam logic signed [MW-1:0]   MAXV = MW'((1 <<< MSBI) - 1);
  localparam logic signed [MW-1:0]   MINV = ~MAXV;  // -2**MSBI
  localparam logic signed [MSBI:0]   STEP = (MSBI+1)'(RAMP_STEP);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MAC0 = 3'd1,
    MAC1 = 3'd2,
    MAC2 = 3'd3,
    SAT  = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]        divider;
  logic                 tick;

  logic signed [IW-1:0] in0_q, in1_q, in2_q;
  logic [3:0]           vol0_q, vol1_q, vol2_q;
  logic [2:0]           mask_q;

  logic signed [AW-1:0] acc;
  logic signed [MSBI:0] target;
  logic signed [MSBI:0] cur;
  logic                 clip_q;

  // Shared multiplier operands and products
  logic signed [IW-1:0] mac_in;
  logic [3:0]           mac_vol;
  logic                 mac_en;
  logic signed [PW-1:0] op_a, op_b, prod;
  logic signed [AW-1:0] acc_add;

  // Scaling / saturation
  logic signed [MW-1:0] acc_w, mix_w;
  logic signed [MSBI:0] sat_val;
  logic                 sat_clip;

  // Slew limiter
  logic signed [MSBI+1:0] diff;
  logic [MSBI+1:0]        absdiff;
  logic signed [MSBI:0]   cur_nx;

  assign tick      = (divider == DW'(CLK_DIV - 1));
  assign dbg_state = state;

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (tick) state_nx = MAC0;
      MAC0:    state_nx = MAC1;
      MAC1:    state_nx = MAC2;
      MAC2:    state_nx = SAT;
      SAT:     state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Multiplier operand select: the MAC state picks the channel.
  always_comb begin
    mac_in  = in0_q;
    mac_vol = vol0_q;
    mac_en  = mask_q[0];
    case (state)
      MAC1: begin
        mac_in  = in1_q;
        mac_vol = vol1_q;
        mac_en  = mask_q[1];
      end
      MAC2: begin
        mac_in  = in2_q;
        mac_vol = vol2_q;
        mac_en  = mask_q[2];
      end
      default: ;
    endcase
  end

  // Operands are widened to the product width first so the multiply is
  // evaluated at full precision; a masked channel contributes zero.
  always_comb begin
    op_a    = mac_en ? {{5{mac_in[IW-1]}}, mac_in} : '0;
    op_b    = {{IW{1'b0}}, 1'b0, mac_vol};
    prod    = op_a * op_b;
    acc_add = acc + {prod[PW-1], prod};
  end

  // mix = (acc <<< SH) >>> 4, arithmetic, floor toward -inf, then clamp.
  always_comb begin
    acc_w    = MW'(acc);
    mix_w    = (acc_w <<< SH) >>> 4;
    sat_clip = 1'b0;
    if (mix_w > MAXV) begin
      sat_val  = MAXV[MSBI:0];
      sat_clip = 1'b1;
    end else if (mix_w < MINV) begin
      sat_val  = MINV[MSBI:0];
      sat_clip = 1'b1;
    end else begin
      sat_val  = mix_w[MSBI:0];
    end
  end

  // Slew limiter: jump to target when close enough, otherwise step exactly
  // RAMP_STEP toward it.
  always_comb begin
    diff    = {target[MSBI], target} - {cur[MSBI], cur};
    absdiff = diff[MSBI+1] ? $unsigned(-diff) : $unsigned(diff);
    cur_nx  = target;
    if (RAMP_STEP != 0 && int'(absdiff) > RAMP_STEP) begin
      if (diff[MSBI+1]) cur_nx = cur - STEP;
      else              cur_nx = cur + STEP;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      divider        <= '0;
      state          <= IDLE;
      acc            <= '0;
      cur            <= '0;
      target         <= '0;
      clip_q         <= 1'b0;
      in0_q          <= '0;
      in1_q          <= '0;
      in2_q          <= '0;
      vol0_q         <= '0;
      vol1_q         <= '0;
      vol2_q         <= '0;
      mask_q         <= '0;
      bus.DAC_OUT    <= {1'b1, {MSBI{1'b0}}};
      bus.SAMPLE_STB <= 1'b0;
      bus.CLIP       <= 1'b0;
    end else begin
      divider        <= tick ? '0 : divider + 1'b1;
      state          <= state_nx;
      bus.SAMPLE_STB <= 1'b0;
      bus.CLIP       <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) begin
            in0_q  <= bus.CH0_IN;
            in1_q  <= bus.CH1_IN;
            in2_q  <= bus.CH2_IN;
            vol0_q <= bus.CH0_VOL;
            vol1_q <= bus.CH1_VOL;
            vol2_q <= bus.CH2_VOL;
            mask_q <= bus.CH_MASK;
            acc    <= '0;
          end
        end
        MAC0, MAC1, MAC2: acc <= acc_add;
        SAT: begin
          target <= bus.EN ? sat_val : '0;
          clip_q <= sat_clip;
        end
        OUT: begin
          cur            <= cur_nx;
          bus.DAC_OUT    <= {~cur_nx[MSBI], cur_nx[MSBI-1:0]};
          bus.SAMPLE_STB <= 1'b1;
          bus.CLIP       <= clip_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_audio_mixer.sv
// tb_dac_audio_mixer -- directed bench for dac_audio_mixer.
//
// Two mixers share the same stimulus and reset: dut0 has no slew limiting,
// dut1 uses RAMP_STEP = 1024. Both run CLK_DIV = 16, so they strobe together.
module tb_dac_audio_mixer;

  localparam int MSBI    = 13;
  localparam int IW      = 12;
  localparam int CLK_DIV = 16;

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  // ---------------- stimulus variables ----------------
  logic                 en   = 1'b1;
  logic signed [IW-1:0] ch0  = '0;
  logic signed [IW-1:0] ch1  = '0;
  logic signed [IW-1:0] ch2  = '0;
  logic [3:0]           v0   = '0;
  logic [3:0]           v1   = '0;
  logic [3:0]           v2   = '0;
  logic [2:0]           mask = '0;

  dac_audio_mixer_if #(.MSBI(MSBI), .IW(IW)) bus0();
  dac_audio_mixer_if #(.MSBI(MSBI), .IW(IW)) bus1();

  assign bus0.EN = en;      assign bus1.EN = en;
  assign bus0.CH0_IN = ch0; assign bus1.CH0_IN = ch0;
  assign bus0.CH1_IN = ch1; assign bus1.CH1_IN = ch1;
  assign bus0.CH2_IN = ch2; assign bus1.CH2_IN = ch2;
  assign bus0.CH0_VOL = v0; assign bus1.CH0_VOL = v0;
  assign bus0.CH1_VOL = v1; assign bus1.CH1_VOL = v1;
  assign bus0.CH2_VOL = v2; assign bus1.CH2_VOL = v2;
  assign bus0.CH_MASK = mask; assign bus1.CH_MASK = mask;

  logic [2:0] dbg0, dbg1;

  dac_audio_mixer #(.MSBI(MSBI), .IW(IW), .CLK_DIV(CLK_DIV), .RAMP_STEP(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .bus(bus0), .dbg_state(dbg0)
  );

  dac_audio_mixer #(.MSBI(MSBI), .IW(IW), .CLK_DIV(CLK_DIV), .RAMP_STEP(1024)) dut1 (
    .CLK(CLK), .RESET(RESET), .bus(bus1), .dbg_state(dbg1)
  );

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance negedge by negedge until dut0 strobes; n = clock edges taken,
  // or 64 if the strobe never arrived.
  task automatic wait_stb(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (bus0.SAMPLE_STB !== 1'b1 && n < 64);
  endtask

  task automatic set_ch(input logic signed [IW-1:0] a, b, c,
                        input logic [3:0] va, vb, vc, input logic [2:0] m);
    ch0 = a; ch1 = b; ch2 = c; v0 = va; v1 = vb; v2 = vc; mask = m;
  endtask

  int n;

  // Hand-computed expectations (MSBI=13, IW=12): mix = in*vol*4/16.
  //   1000*15      -> 3750  -> 11942
  //   -1000*8      -> -2000 -> 6192
  //   3*2047*15    -> 23028 -> clamp 8191 -> 16383
  //   3*-2048*15   -> -23040 -> clamp -8192 -> 0
  //   500*15       -> 1875  -> 10067
  //   100*15       -> 375   -> 8567
  initial begin
    // Reset
    repeat (3) @(negedge CLK);
    check("rst_dac0",  bus0.DAC_OUT, 8192);
    check("rst_dac1",  bus1.DAC_OUT, 8192);
    check("rst_stb",   bus0.SAMPLE_STB, 0);
    check("rst_clip",  bus0.CLIP, 0);
    check("rst_state", dbg1, 0);
    RESET = 1'b0;
    // The tick edge is the 16th edge after release; the strobe lands 5 later.
    wait_stb(n);
    check("first_stb_lat", n, 21);
    check("zero_mask_dac", bus0.DAC_OUT, 8192);
    wait_stb(n);
    check("stb_period", n, CLK_DIV);

    // Single channel + ramp from midscale
    set_ch(1000, 0, 0, 15, 0, 0, 3'b001);
    wait_stb(n);
    check("ch0_pos_dac", bus0.DAC_OUT, 11942);
    check("ch0_pos_clip", bus0.CLIP, 0);
    check("ramp_up1", bus1.DAC_OUT, 9216);
    check("ramp_clip", bus1.CLIP, 0);
    wait_stb(n);
    check("ramp_up2", bus1.DAC_OUT, 10240);
    wait_stb(n);
    check("ramp_up3", bus1.DAC_OUT, 11264);
    wait_stb(n);
    check("ramp_up4", bus1.DAC_OUT, 11942);
    check("hold_dac0", bus0.DAC_OUT, 11942);

    // Disable ramps back to midscale
    en = 1'b0;
    wait_stb(n);
    check("dis_dac0", bus0.DAC_OUT, 8192);
    check("ramp_dn1", bus1.DAC_OUT, 10918);
    wait_stb(n);
    check("ramp_dn2", bus1.DAC_OUT, 9894);
    wait_stb(n);
    check("ramp_dn3", bus1.DAC_OUT, 8870);
    wait_stb(n);
    check("ramp_dn4", bus1.DAC_OUT, 8192);
    wait_stb(n);
    check("ramp_stay", bus1.DAC_OUT, 8192);
    en = 1'b1;

    // Negative input, partial gain
    set_ch(-1000, 0, 0, 8, 0, 0, 3'b001);
    wait_stb(n);
    check("ch0_neg_dac", bus0.DAC_OUT, 6192);
    check("ch0_neg_clip", bus0.CLIP, 0);

    // Saturation both ways; CLIP is a single-cycle pulse
    set_ch(2047, 2047, 2047, 15, 15, 15, 3'b111);
    wait_stb(n);
    check("sat_pos_dac", bus0.DAC_OUT, 16383);
    check("sat_pos_clip", bus0.CLIP, 1);
    @(negedge CLK);
    check("clip_not_sticky", bus0.CLIP, 0);
    check("dac_hold", bus0.DAC_OUT, 16383);
    set_ch(-2048, -2048, -2048, 15, 15, 15, 3'b111);
    wait_stb(n);
    check("sat_neg_dac", bus0.DAC_OUT, 0);
    check("sat_neg_clip", bus0.CLIP, 1);

    // All channels masked
    set_ch(1234, -567, 890, 15, 15, 15, 3'b000);
    wait_stb(n);
    check("mask0_dac", bus0.DAC_OUT, 8192);
    check("mask0_clip", bus0.CLIP, 0);

    // Snapshot: a change during MAC1 must wait for the next sample
    set_ch(500, 0, 0, 15, 0, 0, 3'b001);
    wait_stb(n);
    check("snap_base", bus0.DAC_OUT, 10067);
    repeat (12) @(negedge CLK);
    check("snap_in_mac1", dbg0, 2);
    ch0 = 100;
    wait_stb(n);
    check("snap_old", bus0.DAC_OUT, 10067);
    wait_stb(n);
    check("snap_new", bus0.DAC_OUT, 8567);

    // Reset in MAC1 aborts the sample and restarts the divider
    set_ch(1000, 0, 0, 15, 0, 0, 3'b001);
    repeat (12) @(negedge CLK);
    check("mid_in_mac1", dbg0, 2);
    RESET = 1'b1;
    @(negedge CLK);
    check("mid_rst_dac", bus0.DAC_OUT, 8192);
    check("mid_rst_stb", bus0.SAMPLE_STB, 0);
    check("mid_rst_state", dbg0, 0);
    RESET = 1'b0;
    wait_stb(n);
    check("mid_rst_lat", n, 21);
    check("mid_rst_dac_after", bus0.DAC_OUT, 11942);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

endmodule
